// File: rtl/lane_reorder_collector.sv
`default_nettype none
// ============================================================================
//  Module      : lane_reorder_collector
//  Description : Collects result blocks from NUM_LANES parallel processing
//                lanes, each tagged with a sequence ID. Each lane has one
//                holding slot. Blocks are released in strict sequence order
//                through a registered valid/ready output stage. The module
//                also flags ordering/deadlock conditions and stall timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_reorder_collector #(
    parameter int BLOCK_WIDTH       = 32,
    parameter int NUM_LANES         = 4,
    parameter int SEQUENCE_ID_WIDTH = 8,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [BLOCK_WIDTH-1:0]       lane_data   [NUM_LANES],
    input  logic [SEQUENCE_ID_WIDTH-1:0] lane_seq_id [NUM_LANES],
    input  logic [NUM_LANES-1:0]         lane_valid,
    output logic [NUM_LANES-1:0]         lane_ready,
    output logic [BLOCK_WIDTH-1:0]       data_out,
    output logic [SEQUENCE_ID_WIDTH-1:0] data_out_seq_id,
    output logic                         data_out_valid,
    input  logic                         data_out_ready,
    output logic [SEQUENCE_ID_WIDTH-1:0] expected_seq,
    output logic                         order_err,
    output logic                         timeout_err,
    input  logic                         clear_err
);

    localparam int c_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);

    // Per-lane holding slots
    logic [NUM_LANES-1:0]         r_hold_valid;
    logic [BLOCK_WIDTH-1:0]       r_hold_data [NUM_LANES];
    logic [SEQUENCE_ID_WIDTH-1:0] r_hold_seq  [NUM_LANES];

    // Output stage and sequencing state
    logic [BLOCK_WIDTH-1:0]       r_out_data;
    logic [SEQUENCE_ID_WIDTH-1:0] r_out_seq;
    logic                         r_out_valid;
    logic [SEQUENCE_ID_WIDTH-1:0] r_expected_seq;
    logic                         r_order_err;
    logic                         r_timeout_err;
    logic [c_CNT_W-1:0]           r_stall_cnt;

    // Combinational decision signals
    logic [NUM_LANES-1:0]         w_match;
    logic                         w_any_match;
    logic                         w_multi_match;
    logic [c_IDX_W-1:0]           w_win_idx;
    logic                         w_out_free;
    logic                         w_load;
    logic                         w_order_set;
    logic                         w_stalling;
    logic [c_CNT_W-1:0]           w_stall_inc;
    logic                         w_timeout_set;

    // A slot matches when it holds the sequence ID due for release next
    always_comb begin
        w_match = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_match[k] = r_hold_valid[k] && (r_hold_seq[k] == r_expected_seq);
        end
    end

    // Lowest-index matching slot wins; scanning downward leaves the lowest
    always_comb begin
        w_win_idx   = '0;
        w_any_match = 1'b0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_win_idx   = c_IDX_W'(k);
                w_any_match = 1'b1;
            end
        end
    end

    // More than one bit set means a duplicate ID is sitting in the slots
    assign w_multi_match = |(w_match & (w_match - NUM_LANES'(1)));
    assign w_out_free    = !r_out_valid || data_out_ready;
    assign w_load        = w_any_match && w_out_free;

    // Every slot occupied with nothing releasable can never make progress
    assign w_order_set   = (&r_hold_valid && !w_any_match) || w_multi_match;

    assign w_stalling    = |r_hold_valid && !w_load;
    assign w_stall_inc   = (r_stall_cnt == c_TIMEOUT) ? c_TIMEOUT
                                                      : r_stall_cnt + c_CNT_W'(1);
    // Fires only on the transition into the saturated value
    assign w_timeout_set = w_stalling && (r_stall_cnt != c_TIMEOUT)
                                      && (w_stall_inc == c_TIMEOUT);

    // Slot capture and release; a slot being released is not refilled that edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_valid <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                r_hold_data[k] <= '0;
                r_hold_seq[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (w_load && (w_win_idx == c_IDX_W'(k))) begin
                    r_hold_valid[k] <= 1'b0;
                end else if (lane_valid[k] && !r_hold_valid[k]) begin
                    r_hold_valid[k] <= 1'b1;
                    r_hold_data[k]  <= lane_data[k];
                    r_hold_seq[k]   <= lane_seq_id[k];
                end
            end
        end
    end

    // Output register: load the winner when free, hold while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_seq   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= r_hold_data[w_win_idx];
            r_out_seq   <= r_hold_seq[w_win_idx];
            r_out_valid <= 1'b1;
        end else if (data_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Next ID to release advances on every load and wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_expected_seq <= '0;
        end else if (w_load) begin
            r_expected_seq <= r_expected_seq + SEQUENCE_ID_WIDTH'(1);
        end
    end

    // Sticky errors and stall counter; a new set condition beats clear_err
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_order_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            if (w_order_set) begin
                r_order_err <= 1'b1;
            end else if (clear_err) begin
                r_order_err <= 1'b0;
            end

            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end else if (clear_err) begin
                r_timeout_err <= 1'b0;
            end

            if (!w_stalling) begin
                r_stall_cnt <= '0;
            end else if (clear_err && !w_timeout_set) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= w_stall_inc;
            end
        end
    end

    assign lane_ready      = ~r_hold_valid;
    assign data_out        = r_out_data;
    assign data_out_seq_id = r_out_seq;
    assign data_out_valid  = r_out_valid;
    assign expected_seq    = r_expected_seq;
    assign order_err       = r_order_err;
    assign timeout_err     = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_lane_reorder_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lane_reorder_collector
//  Description : Self-checking bench for lane_reorder_collector. Directed
//                scenarios plus a randomized run scored against an in-order
//                stream model (sequence number -> data table).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_reorder_collector;

    localparam int BW = 32;
    localparam int NL = 4;
    localparam int SW = 8;
    localparam int TO = 16;
    localparam int NB = 260;

    logic          clk;
    logic          rst_n;
    logic [BW-1:0] lane_data   [NL];
    logic [SW-1:0] lane_seq_id [NL];
    logic [NL-1:0] lane_valid;
    logic [NL-1:0] lane_ready;
    logic [BW-1:0] data_out;
    logic [SW-1:0] data_out_seq_id;
    logic          data_out_valid;
    logic          data_out_ready;
    logic [SW-1:0] expected_seq;
    logic          order_err;
    logic          timeout_err;
    logic          clear_err;

    int n_vec = 0;
    int n_err = 0;

    lane_reorder_collector #(
        .BLOCK_WIDTH      (BW),
        .NUM_LANES        (NL),
        .SEQUENCE_ID_WIDTH(SW),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lane_data      (lane_data),
        .lane_seq_id    (lane_seq_id),
        .lane_valid     (lane_valid),
        .lane_ready     (lane_ready),
        .data_out       (data_out),
        .data_out_seq_id(data_out_seq_id),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .expected_seq   (expected_seq),
        .order_err      (order_err),
        .timeout_err    (timeout_err),
        .clear_err      (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        lane_valid = '0;
        clear_err  = 1'b0;
        for (int k = 0; k < NL; k++) begin
            lane_data[k]   = '0;
            lane_seq_id[k] = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        data_out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic put_lane(input int k, input int seq, input logic [BW-1:0] d);
        lane_valid[k]  = 1'b1;
        lane_seq_id[k] = SW'(seq);
        lane_data[k]   = d;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (lane_ready !== 4'hF) begin
            n_err++; $display("FAIL reset lane_ready: got %b want 1111", lane_ready);
        end
        n_vec++;
        if ({data_out_valid, data_out_seq_id, data_out} !== {1'b0, 8'h00, 32'h0}) begin
            n_err++; $display("FAIL reset output: got v=%b s=%h d=%h want 0/00/0", data_out_valid, data_out_seq_id, data_out);
        end
        n_vec++;
        if ({expected_seq, order_err, timeout_err} !== {8'h00, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset state: got exp=%h oe=%b te=%b want 00/0/0", expected_seq, order_err, timeout_err);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        for (int k = 0; k < NL; k++) put_lane(k, k, 32'hA0000000 + 32'(k));
        @(posedge clk); #1;
        lane_valid = '0;
        n_vec++;
        if (lane_ready !== 4'h0) begin
            n_err++; $display("FAIL in_order capture lane_ready: got %b want 0000", lane_ready);
        end
        for (int i = 0; i < NL; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({data_out_valid, data_out_seq_id, data_out} !== {1'b1, 8'(i), 32'hA0000000 + 32'(i)}) begin
                n_err++; $display("FAIL in_order out[%0d]: got v=%b s=%h d=%h want 1/%h/%h", i, data_out_valid, data_out_seq_id, data_out, 8'(i), 32'hA0000000 + 32'(i));
            end
        end
        n_vec++;
        if (expected_seq !== 8'd4) begin
            n_err++; $display("FAIL in_order expected_seq: got %0d want 4", expected_seq);
        end
        @(posedge clk); #1;
        n_vec++;
        if (data_out_valid !== 1'b0) begin
            n_err++; $display("FAIL in_order drain valid: got %b want 0", data_out_valid);
        end
    endtask

    task automatic test_reorder();
        int order [4] = '{3, 1, 0, 2};
        logic [SW-1:0] got [$];
        bit seen3 = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 10; cyc++) begin
            lane_valid = '0;
            if (cyc < 4) put_lane(order[cyc], order[cyc], 32'hB0000000 + 32'(order[cyc]));
            @(posedge clk); #1;
            lane_valid = '0;
            if (data_out_valid) begin
                got.push_back(data_out_seq_id);
                if (data_out_seq_id == 8'd3) seen3 = 1'b1;
            end
            n_vec++;
            if (lane_ready[3] !== seen3) begin
                n_err++; $display("FAIL reorder lane_ready[3] cyc %0d: got %b want %b", cyc, lane_ready[3], seen3);
            end
        end
        n_vec++;
        if (got.size() != 4) begin
            n_err++; $display("FAIL reorder count: got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (got[i] !== 8'(i)) begin
                    n_err++; $display("FAIL reorder order[%0d]: got %0d want %0d", i, got[i], i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        data_out_ready = 1'b0;
        put_lane(0, 0, 32'hA0000000);
        put_lane(1, 1, 32'hA0000001);
        @(posedge clk); #1;
        lane_valid = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({data_out_valid, data_out_seq_id, data_out, expected_seq} !== {1'b1, 8'd0, 32'hA0000000, 8'd1}) begin
                n_err++; $display("FAIL backpressure hold[%0d]: got v=%b s=%h d=%h exp=%h want 1/00/a0000000/01", i, data_out_valid, data_out_seq_id, data_out, expected_seq);
            end
            @(posedge clk); #1;
        end
        data_out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({data_out_valid, data_out_seq_id, data_out, expected_seq} !== {1'b1, 8'd1, 32'hA0000001, 8'd2}) begin
            n_err++; $display("FAIL backpressure release: got v=%b s=%h d=%h exp=%h want 1/01/a0000001/02", data_out_valid, data_out_seq_id, data_out, expected_seq);
        end
        @(posedge clk); #1;
        n_vec++;
        if (data_out_valid !== 1'b0) begin
            n_err++; $display("FAIL backpressure drain valid: got %b want 0", data_out_valid);
        end
    endtask

    task automatic test_errors();
        // All slots full with IDs that can never match
        do_reset();
        for (int k = 0; k < NL; k++) put_lane(k, 5 + k, 32'hC0000000 + 32'(k));
        @(posedge clk); #1;
        lane_valid = '0;
        n_vec++;
        if (order_err !== 1'b0) begin
            n_err++; $display("FAIL errors order_err early: got %b want 0", order_err);
        end
        @(posedge clk); #1;
        n_vec++;
        if (order_err !== 1'b1) begin
            n_err++; $display("FAIL errors order_err deadlock: got %b want 1", order_err);
        end
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        n_vec++;
        if (order_err !== 1'b1) begin
            n_err++; $display("FAIL errors set beats clear: got %b want 1", order_err);
        end

        // Duplicate ID in two slots
        do_reset();
        put_lane(0, 0, 32'h1);
        put_lane(1, 0, 32'h2);
        @(posedge clk); #1;
        lane_valid = '0;
        @(posedge clk); #1;
        n_vec++;
        if ({order_err, data_out_valid, data_out} !== {1'b1, 1'b1, 32'h1}) begin
            n_err++; $display("FAIL errors duplicate: got oe=%b v=%b d=%h want 1/1/00000001", order_err, data_out_valid, data_out);
        end
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        n_vec++;
        if (order_err !== 1'b0) begin
            n_err++; $display("FAIL errors clear order_err: got %b want 0", order_err);
        end

        // Single slot waiting forever for a missing ID
        do_reset();
        put_lane(0, 1, 32'hD0000001);
        @(posedge clk); #1;
        lane_valid = '0;
        repeat (TO - 1) @(posedge clk);
        #1;
        n_vec++;
        if (timeout_err !== 1'b0) begin
            n_err++; $display("FAIL errors timeout early: got %b want 0", timeout_err);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({timeout_err, order_err} !== 2'b10) begin
            n_err++; $display("FAIL errors timeout at limit: got te=%b oe=%b want 1/0", timeout_err, order_err);
        end
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        n_vec++;
        if ({timeout_err, order_err} !== 2'b00) begin
            n_err++; $display("FAIL errors clear both: got te=%b oe=%b want 0/0", timeout_err, order_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_out_ready = 1'b0;
        put_lane(0, 0, 32'hE0000000);
        put_lane(2, 2, 32'hE0000002);
        put_lane(3, 3, 32'hE0000003);
        @(posedge clk); #1;
        lane_valid = '0;
        @(posedge clk); #1;
        n_vec++;
        if ({data_out_valid, lane_ready} !== {1'b1, 4'b0011}) begin
            n_err++; $display("FAIL reset_mid before: got v=%b rdy=%b want 1/0011", data_out_valid, lane_ready);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({data_out_valid, lane_ready, expected_seq, order_err, timeout_err} !== {1'b0, 4'hF, 8'd0, 2'b00}) begin
            n_err++; $display("FAIL reset_mid first edge: got v=%b rdy=%b exp=%h oe=%b te=%b want 0/1111/00/0/0", data_out_valid, lane_ready, expected_seq, order_err, timeout_err);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({data_out_valid, lane_ready, expected_seq} !== {1'b0, 4'hF, 8'd0}) begin
            n_err++; $display("FAIL reset_mid after: got v=%b rdy=%b exp=%h want 0/1111/00", data_out_valid, lane_ready, expected_seq);
        end
    endtask

    // Random IDs within a four-wide window ahead of the accepted count; the
    // model is simply "accepted stream equals 0,1,2,... with table data".
    task automatic test_random_wrap();
        logic [BW-1:0] dtab [NB];
        bit            issued [NB];
        bit            busy [NL];
        int            cand [$];
        int            next_out = 0;
        int            cyc = 0;
        int            p;
        bit            prev_hold = 1'b0;
        logic [BW-1:0] prev_d = '0;
        logic [SW-1:0] prev_s = '0;
        for (int i = 0; i < NB; i++) begin
            dtab[i]   = $urandom;
            issued[i] = 1'b0;
        end
        for (int k = 0; k < NL; k++) busy[k] = 1'b0;
        do_reset();
        while (next_out < NB && cyc < 5000) begin
            for (int k = 0; k < NL; k++) begin
                if (!busy[k]) begin
                    lane_valid[k] = 1'b0;
                    if (lane_ready[k] && $urandom_range(0, 3) != 0) begin
                        cand.delete();
                        for (int c = next_out; c < next_out + NL && c < NB; c++)
                            if (!issued[c]) cand.push_back(c);
                        if (cand.size() > 0) begin
                            p = cand[$urandom_range(0, cand.size() - 1)];
                            issued[p] = 1'b1;
                            busy[k]   = 1'b1;
                            put_lane(k, p, dtab[p]);
                        end
                    end
                end
            end
            data_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (prev_hold) begin
                n_vec++;
                if ({data_out_valid, data_out_seq_id, data_out} !== {1'b1, prev_s, prev_d}) begin
                    n_err++; $display("FAIL random stable: got v=%b s=%h d=%h want 1/%h/%h", data_out_valid, data_out_seq_id, data_out, prev_s, prev_d);
                end
            end
            prev_hold = 1'b0;
            if (data_out_valid) begin
                if (data_out_ready) begin
                    n_vec++;
                    if ({data_out_seq_id, data_out} !== {SW'(next_out), dtab[next_out]}) begin
                        n_err++; $display("FAIL random out #%0d: got s=%h d=%h want %h/%h", next_out, data_out_seq_id, data_out, SW'(next_out), dtab[next_out]);
                    end
                    next_out++;
                end else begin
                    prev_hold = 1'b1;
                    prev_s    = data_out_seq_id;
                    prev_d    = data_out;
                end
            end
            for (int k = 0; k < NL; k++)
                if (lane_valid[k] && lane_ready[k]) busy[k] = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        lane_valid = '0;
        n_vec++;
        if (next_out != NB) begin
            n_err++; $display("FAIL random completion: got %0d outputs want %0d", next_out, NB);
        end
        n_vec++;
        if ({expected_seq, order_err, timeout_err} !== {SW'(NB), 2'b00}) begin
            n_err++; $display("FAIL random end state: got exp=%h oe=%b te=%b want %h/0/0", expected_seq, order_err, timeout_err, SW'(NB));
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        data_out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_in_order();
        test_reorder();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_random_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lane_reorder_collector.md
LANE_REORDER_COLLECTOR -- requirements
Module: lane_reorder_collector

Interface
REQ-001 SHALL have parameter BLOCK_WIDTH, default 32, width of one data block.
REQ-002 SHALL have parameter NUM_LANES, default 4, number of processing lanes collected.
REQ-003 SHALL have parameter SEQUENCE_ID_WIDTH, default 8, width of sequence IDs.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, stall cycles before timeout_err is flagged.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port lane_data  input  [BLOCK_WIDTH-1:0] x NUM_LANES (unpacked)  per-lane result block.
REQ-008 SHALL have port lane_seq_id  input  [SEQUENCE_ID_WIDTH-1:0] x NUM_LANES  per-lane result sequence ID.
REQ-009 SHALL have port lane_valid  input  1 x NUM_LANES  per-lane result valid.
REQ-010 SHALL have port lane_ready  output  1 x NUM_LANES  per-lane holding slot free.
REQ-011 SHALL have port data_out  output  BLOCK_WIDTH  in-order output block.
REQ-012 SHALL have port data_out_seq_id  output  SEQUENCE_ID_WIDTH  sequence ID of data_out.
REQ-013 SHALL have port data_out_valid  output  1  output valid.
REQ-014 SHALL have port data_out_ready  input  1  downstream accept.
REQ-015 SHALL have port expected_seq  output  SEQUENCE_ID_WIDTH  next sequence ID to be released.
REQ-016 SHALL have port order_err  output  1  sticky ordering/deadlock error.
REQ-017 SHALL have port timeout_err  output  1  sticky stall timeout error.
REQ-018 SHALL have port clear_err  input  1  single-cycle pulse clearing both sticky errors.

Function
REQ-019 SHALL hold one registered slot per lane (hold_valid, hold_data, hold_seq); lane_ready[k] = !hold_valid[k], driven from register only.
REQ-020 SHALL capture lane k into its slot at an edge where lane_valid[k] && lane_ready[k]; the slot is not writable in the cycle it is released.
REQ-021 SHALL mark slot k matching when hold_valid[k] && hold_seq[k] == expected_seq; the lowest matching index wins.
REQ-022 SHALL load the winning slot into the output register when !data_out_valid || data_out_ready, clearing that slot and incrementing expected_seq in the same edge.
REQ-023 SHALL give latency: lane handshake at edge t -> data_out_valid high after edge t+1, given a match and a free output.
REQ-024 SHALL sustain one output per cycle when consecutive IDs sit in different slots and data_out_ready=1.
REQ-025 SHALL keep data_out/data_out_seq_id stable while data_out_valid && !data_out_ready.
REQ-026 SHALL increment expected_seq modulo 2^SEQUENCE_ID_WIDTH (max wraps to 0).
REQ-027 SHALL set order_err when all NUM_LANES slots are valid and none match, or when two or more slots match simultaneously.
REQ-028 SHALL count stall cycles while any hold_valid is high and no output load occurs; the counter clears on any load or when all slots are empty.
REQ-029 SHALL set timeout_err when the stall counter reaches TIMEOUT_CYCLES; the counter saturates there.
REQ-030 SHALL clear order_err, timeout_err and the stall counter on clear_err; a set condition in the same cycle wins over clear.

Reset
REQ-031 SHALL, with rst_n=0 at an edge, clear all hold_valid, data_out_valid, order_err, timeout_err and the stall counter, set expected_seq=0, and zero data_out and data_out_seq_id.
REQ-032 SHALL discard in-flight slots and the output register on reset mid-operation; lane_ready[k]=1 after the first edge with rst_n=0.

Verification
REQ-033 SHALL cover in-order delivery: lanes 0..3 present seq 0..3 in one cycle, data_out_ready=1 -> data_out_seq_id 0,1,2,3 on four consecutive cycles, expected_seq=4.
REQ-034 SHALL cover reordering: lane3 seq3, then lane1 seq1, lane0 seq0, lane2 seq2 -> outputs ordered 0,1,2,3; lane_ready[3]=0 until seq3 is released.
REQ-035 SHALL cover backpressure: data_out_ready=0 for 5 cycles with seq0 output -> data_out 32'hA0000000 stable, expected_seq=1 unchanged; then release -> next ID follows.
REQ-036 SHALL cover wrap: 260 blocks round-robin across lanes -> seq 255 is immediately followed by seq 0; no errors.
REQ-037 SHALL cover errors: expected_seq=0, lanes deliver seq 5,6,7,8 -> order_err=1 next cycle; with TIMEOUT_CYCLES=16 and lane0 seq1 only -> timeout_err=1 after 16 stall cycles; clear_err -> both errors 0.
REQ-038 SHALL cover reset mid-operation: two slots full, rst_n=0 for 3 cycles -> data_out_valid=0, all lane_ready=1, expected_seq=0, errors 0.
